// File: rtl/tmds_multi_encoder.sv
// NUM_CH-lane TMDS encoder: video 8b/10b with running disparity, control, TERC4 and guard-band
// symbols. Stage 1 builds the transition-minimised q_m word; stage 2 picks and registers the symbol.
module tmds_multi_encoder #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                  clklow,
    input  logic                  reset,
    input  logic [2:0]            mode,
    input  logic [8*NUM_CH-1:0]   pix_data,
    input  logic [2*NUM_CH-1:0]   ctrl,
    input  logic [4*NUM_CH-1:0]   aux_data,
    output logic [10*NUM_CH-1:0]  q_out,
    output logic                  q_valid
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_DATA   = 3'd2;
    localparam logic [2:0] MODE_VGUARD = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00: s = 10'b1101010100;
            2'b01: s = 10'b0010101011;
            2'b10: s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    // Shared stage-1 state: every lane is in the same mode on a given symbol
    logic [2:0] mode_reg;
    logic       valid1_reg;
    logic       valid2_reg;

    always_ff @(posedge clklow) begin
        if (reset) begin
            mode_reg   <= MODE_CTRL;
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
        end else begin
            mode_reg   <= mode;
            valid1_reg <= 1'b1;
            valid2_reg <= valid1_reg;
        end
    end

    assign q_valid = valid2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            localparam logic [9:0] VGUARD_SYM = ((gi % 2) == 0) ? GUARD_EVEN : GUARD_ODD;

            logic [7:0] d;
            logic [3:0] n1;
            logic       use_xnor;
            logic [8:0] qm_next;
            logic [8:0] qm_reg;
            logic [1:0] ctrl_reg;
            logic [3:0] aux_reg;

            assign d = pix_data[8*gi +: 8];

            always_comb begin
                n1         = popcount8(d);
                use_xnor   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
                qm_next    = 9'd0;
                qm_next[0] = d[0];
                for (int i = 1; i < 8; i++) begin
                    qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d[i]) : (qm_next[i-1] ^ d[i]);
                end
                qm_next[8] = ~use_xnor;
            end

            always_ff @(posedge clklow) begin
                if (reset) begin
                    qm_reg   <= 9'd0;
                    ctrl_reg <= 2'd0;
                    aux_reg  <= 4'd0;
                end else begin
                    qm_reg   <= qm_next;
                    ctrl_reg <= ctrl[2*gi +: 2];
                    aux_reg  <= aux_data[4*gi +: 4];
                end
            end

            logic [3:0]               ones;
            logic signed [DISP_W-1:0] n1_s;
            logic signed [DISP_W-1:0] n0_s;
            logic signed [DISP_W-1:0] bal;
            logic signed [DISP_W-1:0] two_q8;
            logic signed [DISP_W-1:0] two_nq8;
            logic signed [DISP_W-1:0] cnt_reg;
            logic signed [DISP_W-1:0] cnt_next;
            logic [9:0]               vid_sym;
            logic signed [DISP_W-1:0] vid_cnt;
            logic [9:0]               sym_next;
            logic [9:0]               sym_reg;

            always_comb begin
                ones    = popcount8(qm_reg[7:0]);
                n1_s    = DISP_W'(ones);
                n0_s    = DISP_W'(4'd8 - ones);
                bal     = n1_s - n0_s;
                two_q8  = qm_reg[8] ? DISP_W'(2) : DISP_W'(0);
                two_nq8 = qm_reg[8] ? DISP_W'(0) : DISP_W'(2);
                if ((cnt_reg == 0) || (bal == 0)) begin
                    vid_sym = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
                    vid_cnt = qm_reg[8] ? (cnt_reg + bal) : (cnt_reg - bal);
                end else if (((cnt_reg > 0) && (bal > 0)) || ((cnt_reg < 0) && (bal < 0))) begin
                    vid_sym = {1'b1, qm_reg[8], ~qm_reg[7:0]};
                    vid_cnt = cnt_reg + two_q8 - bal;
                end else begin
                    vid_sym = {1'b0, qm_reg[8], qm_reg[7:0]};
                    vid_cnt = cnt_reg + bal - two_nq8;
                end
            end

            // Any non-video symbol zeroes the disparity so each video period starts balanced
            always_comb begin
                sym_next = 10'd0;
                cnt_next = '0;
                if (valid1_reg) begin
                    case (mode_reg)
                        MODE_CTRL:   sym_next = ctrl_sym(ctrl_reg);
                        MODE_VIDEO: begin
                            sym_next = vid_sym;
                            cnt_next = vid_cnt;
                        end
                        MODE_DATA:   sym_next = terc4(aux_reg);
                        MODE_VGUARD: sym_next = VGUARD_SYM;
                        MODE_DGUARD: sym_next = (gi == 0) ? terc4({2'b11, ctrl_reg}) : GUARD_ODD;
                        default:     sym_next = 10'd0;
                    endcase
                end
            end

            always_ff @(posedge clklow) begin
                if (reset) begin
                    sym_reg <= 10'd0;
                    cnt_reg <= '0;
                end else begin
                    sym_reg <= sym_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign q_out[10*gi +: 10] = sym_reg;
        end
    endgenerate

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Directed-vector and reference-model bench for the 3-lane TMDS encoder.
module tb_tmds_multi_encoder;

    logic        clklow = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [23:0] pix_data;
    logic [5:0]  ctrl;
    logic [11:0] aux_data;
    logic [29:0] q_out;
    logic        q_valid;

    int total = 0;
    int bad   = 0;

    localparam int NV    = 20;
    localparam int NRAND = 10000;

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] pix;
        logic [5:0]  ctrl;
        logic [11:0] aux;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs [NV];

    tmds_multi_encoder #(.NUM_CH(3), .DISP_W(5)) dut (
        .clklow   (clklow),
        .reset    (reset),
        .mode     (mode),
        .pix_data (pix_data),
        .ctrl     (ctrl),
        .aux_data (aux_data),
        .q_out    (q_out),
        .q_valid  (q_valid)
    );

    always #5 clklow = ~clklow;

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference video encoder written from the algorithm description
    function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cnt_in, output int cnt_out);
        int n1, ones, zeros;
        logic xn;
        logic [8:0] qm;
        logic [9:0] s;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        ones = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (cnt_in == 0 || ones == zeros) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_out = qm[8] ? cnt_in + ones - zeros : cnt_in + zeros - ones;
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + (qm[8] ? 2 : 0) + zeros - ones;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in + ones - zeros - (qm[8] ? 0 : 2);
        end
        return s;
    endfunction

    function automatic logic [7:0] dec_sym(input logic [9:0] q);
        logic [7:0] t, o;
        t = q[9] ? ~q[7:0] : q[7:0];
        o[0] = t[0];
        for (int i = 1; i < 8; i++) o[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return o;
    endfunction

    initial begin
        int mcnt [3];
        logic [29:0] expq [$];
        logic [23:0] pixq [$];
        logic [29:0] e;
        logic [23:0] p;
        logic [23:0] dec;

        vecs[0]  = '{3'd1, 24'h55FF00, 6'd0, 12'd0, {10'h133, 10'h200, 10'h100}};
        vecs[1]  = '{3'd1, 24'h55FF00, 6'd0, 12'd0, {10'h133, 10'h0FF, 10'h3FF}};
        vecs[2]  = '{3'd1, 24'h0000FF, 6'd0, 12'd0, {10'h100, 10'h3FF, 10'h200}};
        vecs[3]  = '{3'd0, 24'h0, 6'b11_10_01, 12'd0, {10'h2AB, 10'h154, 10'h0AB}};
        vecs[4]  = '{3'd1, 24'hFFFFFF, 6'd0, 12'd0, {10'h200, 10'h200, 10'h200}};
        vecs[5]  = '{3'd0, 24'h0, 6'b00_00_00, 12'd0, {10'h354, 10'h354, 10'h354}};
        vecs[6]  = '{3'd0, 24'h0, 6'b00_11_10, 12'd0, {10'h354, 10'h2AB, 10'h154}};
        vecs[7]  = '{3'd2, 24'h0, 6'd0, 12'h210, {10'h2E4, 10'h263, 10'h29C}};
        vecs[8]  = '{3'd2, 24'h0, 6'd0, 12'h543, {10'h11E, 10'h171, 10'h2E2}};
        vecs[9]  = '{3'd2, 24'h0, 6'd0, 12'h876, {10'h2CC, 10'h13C, 10'h18E}};
        vecs[10] = '{3'd2, 24'h0, 6'd0, 12'hBA9, {10'h2C6, 10'h19C, 10'h139}};
        vecs[11] = '{3'd2, 24'h0, 6'd0, 12'hEDC, {10'h163, 10'h271, 10'h28E}};
        vecs[12] = '{3'd2, 24'h0, 6'd0, 12'hFFF, {10'h2C3, 10'h2C3, 10'h2C3}};
        vecs[13] = '{3'd3, 24'h0, 6'd0, 12'd0, {10'h2CC, 10'h133, 10'h2CC}};
        vecs[14] = '{3'd4, 24'h0, 6'b00_00_10, 12'd0, {10'h133, 10'h133, 10'h163}};
        vecs[15] = '{3'd4, 24'h0, 6'b00_00_01, 12'd0, {10'h133, 10'h133, 10'h271}};
        vecs[16] = '{3'd5, 24'hA5A5A5, 6'b111111, 12'hFFF, 30'd0};
        vecs[17] = '{3'd7, 24'h123456, 6'b101010, 12'h5A5, 30'd0};
        vecs[18] = '{3'd1, 24'h000000, 6'd0, 12'd0, {10'h100, 10'h100, 10'h100}};
        vecs[19] = '{3'd1, 24'h000000, 6'd0, 12'd0, {10'h3FF, 10'h3FF, 10'h3FF}};

        reset = 1'b1; mode = 3'd1; pix_data = 24'hFFFFFF; ctrl = 6'd0; aux_data = 12'd0;
        repeat (3) @(negedge clklow);
        check("reset_q_out", q_out, 30'd0);
        check("reset_q_valid", {29'd0, q_valid}, 30'd0);

        // Directed table, one vector per cycle; each result appears two edges later
        for (int i = 0; i < NV + 2; i++) begin
            if (i > 0) @(negedge clklow);
            if (i == 1) check("valid_first_edge", {29'd0, q_valid}, 30'd0);
            if (i >= 2) begin
                check($sformatf("vec%0d_q_out", i - 2), q_out, vecs[i-2].exp);
                check($sformatf("vec%0d_q_valid", i - 2), {29'd0, q_valid}, 30'd1);
            end
            if (i == 0) reset = 1'b0;
            if (i < NV) begin
                mode = vecs[i].mode; pix_data = vecs[i].pix;
                ctrl = vecs[i].ctrl; aux_data = vecs[i].aux;
            end
        end

        // Reset asserted mid-line during a video period
        @(negedge clklow); reset = 1'b1;
        @(negedge clklow);
        check("midreset_q_out", q_out, 30'd0);
        check("midreset_q_valid", {29'd0, q_valid}, 30'd0);
        @(negedge clklow); reset = 1'b0; mode = 3'd1; pix_data = 24'h000000;
        @(negedge clklow);
        check("release1_q_out", q_out, 30'd0);
        check("release1_q_valid", {29'd0, q_valid}, 30'd0);
        @(negedge clklow);
        check("release2_q_valid", {29'd0, q_valid}, 30'd1);
        check("release2_q_out", q_out, {10'h100, 10'h100, 10'h100});
        @(negedge clklow);
        check("release3_q_out", q_out, {10'h3FF, 10'h3FF, 10'h3FF});

        // Random video stream against the reference model, after a control symbol clears disparity
        mode = 3'd0; ctrl = 6'd0;
        @(negedge clklow);
        for (int l = 0; l < 3; l++) mcnt[l] = 0;
        for (int i = 0; i < NRAND + 2; i++) begin
            @(negedge clklow);
            if (i >= 2) begin
                e = expq.pop_front();
                p = pixq.pop_front();
                check("rand_sym", q_out, e);
                for (int l = 0; l < 3; l++) dec[8*l +: 8] = dec_sym(q_out[10*l +: 10]);
                check("rand_decode", {6'd0, dec}, {6'd0, p});
            end
            if (i < NRAND) begin
                mode = 3'd1;
                p = 24'($urandom);
                pix_data = p;
                for (int l = 0; l < 3; l++) begin
                    int c;
                    e[10*l +: 10] = ref_enc(p[8*l +: 8], mcnt[l], c);
                    mcnt[l] = c;
                end
                expq.push_back(e);
                pixq.push_back(p);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
